// File: rtl/cpu_mem_bridge_if.sv
// Bus bundle between the Cpu core, the cpu_mem_bridge and memory.
// The bridge takes the master view; the core/memory environment takes the slave view.
interface cpu_mem_bridge_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  cpu_req_rdwr;
   logic                  cpu_which_rdwr;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_data_out;
   logic [DATA_WIDTH-1:0] cpu_data_in;
   logic                  cpu_enable;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   logic                  bus_err;

   modport master (
      input  cpu_req_rdwr, cpu_which_rdwr, cpu_addr, cpu_data_out, mem_rdata, mem_ack,
      output cpu_data_in, cpu_enable, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport slave (
      output cpu_req_rdwr, cpu_which_rdwr, cpu_addr, cpu_data_out, mem_rdata, mem_ack,
      input  cpu_data_in, cpu_enable, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Cpu-to-memory req/ack bridge with a minimum wait-state count; stalls the core via cpu_enable.
// Optional access timeout with open-bus read data and a bus_err pulse: define CPU_MEM_BRIDGE_TIMEOUT_EN.
module cpu_mem_bridge #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int WAIT_STATES    = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   cpu_mem_bridge_if.master bus
);
   localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
   localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

   if (WAIT_STATES < 0 || WAIT_STATES > 255 || TIMEOUT_CYCLES <= WAIT_STATES) begin : g_cfg_check
      $error("cpu_mem_bridge: WAIT_STATES must be 0..255 and below TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [7:0]            r_wcnt, w_wcnt_nxt;
   logic                  r_cpu_enable, w_cpu_enable_nxt;
   logic [DATA_WIDTH-1:0] r_cpu_data_in, w_cpu_data_in_nxt;
   logic                  r_mem_req, w_mem_req_nxt;
   logic                  r_mem_we, w_mem_we_nxt;
   logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic                  r_bus_err, w_bus_err_nxt;
   logic                  w_wait_done, w_complete, w_timeout;

   // wcnt+1 > WAIT_STATES is wcnt >= WAIT_STATES without a constant compare when WAIT_STATES is 0
   assign w_wait_done = ({24'd0, r_wcnt} + 32'd1) > 32'(WAIT_STATES);
   assign w_complete  = (r_state == REQ) && bus.mem_ack && w_wait_done;

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
   assign w_timeout = (r_state == REQ) && !w_complete &&
                      (({24'd0, r_wcnt} + 32'd1) >= 32'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      w_state_nxt       = r_state;
      w_wcnt_nxt        = r_wcnt;
      w_cpu_data_in_nxt = r_cpu_data_in;
      w_mem_req_nxt     = r_mem_req;
      w_mem_we_nxt      = r_mem_we;
      w_mem_addr_nxt    = r_mem_addr;
      w_mem_wdata_nxt   = r_mem_wdata;
      w_bus_err_nxt     = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.cpu_req_rdwr) begin
               w_state_nxt     = REQ;
               w_mem_addr_nxt  = bus.cpu_addr;
               w_mem_wdata_nxt = bus.cpu_data_out;
               w_mem_we_nxt    = (bus.cpu_which_rdwr == ENUM__CPU_WH_RDWR__WRITE);
               w_mem_req_nxt   = 1'b1;
               w_wcnt_nxt      = 8'd0;
            end
         end
         REQ: begin
            if (r_wcnt != 8'hFF) w_wcnt_nxt = r_wcnt + 8'd1;
            if (w_complete) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = DONE;
               if (!r_mem_we) w_cpu_data_in_nxt = bus.mem_rdata;
            end else if (w_timeout) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = DONE;
               w_bus_err_nxt = 1'b1;
               if (!r_mem_we) w_cpu_data_in_nxt = '1;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_cpu_enable_nxt = (w_state_nxt != REQ);
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         r_state       <= IDLE;
         r_wcnt        <= 8'd0;
         r_cpu_enable  <= 1'b0;
         r_cpu_data_in <= '0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_bus_err     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wcnt        <= w_wcnt_nxt;
         r_cpu_enable  <= w_cpu_enable_nxt;
         r_cpu_data_in <= w_cpu_data_in_nxt;
         r_mem_req     <= w_mem_req_nxt;
         r_mem_we      <= w_mem_we_nxt;
         r_mem_addr    <= w_mem_addr_nxt;
         r_mem_wdata   <= w_mem_wdata_nxt;
         r_bus_err     <= w_bus_err_nxt;
      end
   end

   assign bus.cpu_enable  = r_cpu_enable;
   assign bus.cpu_data_in = r_cpu_data_in;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.bus_err     = r_bus_err;
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge: one instance with WAIT_STATES=0, one with WAIT_STATES=3.
// Expected accesses are queued when driven and checked when the DUT completes them.
module tb_cpu_mem_bridge;
   localparam logic RD = 1'b0;
   localparam logic WR = 1'b1;

   typedef struct {
      string       tag;
      int          req_cycles;
      int          gap;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  din;
      logic        err;
   } exp_t;

   exp_t sb[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic        req = 1'b0;
   logic        which = RD;
   logic [15:0] addr = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata = '0;
   logic        ack_tied = 1'b1;
   int          ack_after = 0;
   int          req_cnt = 0;
   int          low_cnt = 0;
   bit          was_req = 1'b0;
   bit          mon_en = 1'b1;
   logic [7:0]  exp_din [2];
   int          n_checks = 0;
   int          n_errors = 0;
   logic        ack;

   assign ack = ack_tied | ((ack_after != 0) && (req_cnt >= ack_after));

   cpu_mem_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus0 ();
   cpu_mem_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus3 ();

   assign bus0.cpu_req_rdwr   = !sel && req;
   assign bus0.cpu_which_rdwr = which;
   assign bus0.cpu_addr       = addr;
   assign bus0.cpu_data_out   = wdata;
   assign bus0.mem_rdata      = rdata;
   assign bus0.mem_ack        = ack;
   assign bus3.cpu_req_rdwr   = sel && req;
   assign bus3.cpu_which_rdwr = which;
   assign bus3.cpu_addr       = addr;
   assign bus3.cpu_data_out   = wdata;
   assign bus3.mem_rdata      = rdata;
   assign bus3.mem_ack        = ack;

   cpu_mem_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0), .TIMEOUT_CYCLES(8)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.master)
   );

   cpu_mem_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(3), .TIMEOUT_CYCLES(8)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.master)
   );

   logic        w_mem_req, w_mem_we, w_enable, w_err;
   logic [15:0] w_mem_addr;
   logic [7:0]  w_mem_wdata, w_din;
   assign w_mem_req   = sel ? bus3.mem_req     : bus0.mem_req;
   assign w_mem_we    = sel ? bus3.mem_we      : bus0.mem_we;
   assign w_enable    = sel ? bus3.cpu_enable  : bus0.cpu_enable;
   assign w_err       = sel ? bus3.bus_err     : bus0.bus_err;
   assign w_mem_addr  = sel ? bus3.mem_addr    : bus0.mem_addr;
   assign w_mem_wdata = sel ? bus3.mem_wdata   : bus0.mem_wdata;
   assign w_din       = sel ? bus3.cpu_data_in : bus0.cpu_data_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input string tag, input logic we, input logic [15:0] a,
                           input logic [7:0] d, input int cycles, input int gap,
                           input logic [7:0] rd, input logic err);
      exp_t e;
      e.tag        = tag;
      e.req_cycles = cycles;
      e.gap        = gap;
      e.we         = we;
      e.addr       = a;
      e.wdata      = d;
      e.err        = err;
      if (we) e.din = exp_din[sel];
      else    e.din = err ? 8'hFF : rd;
      exp_din[sel] = e.din;
      sb.push_back(e);
   endtask

   // Single-cycle request pulse; mem_req must already be high in the cycle after the sampling edge.
   task automatic start_access(input string tag, input logic we, input logic [15:0] a,
                               input logic [7:0] d, input int cycles, input logic [7:0] rd,
                               input logic err);
      push_exp(tag, we, a, d, cycles, -1, rd, err);
      @(negedge clk);
      which = we;
      addr  = a;
      wdata = d;
      req   = 1'b1;
      @(negedge clk);
      check({tag, "_lat"}, w_mem_req, 1'b1);
      req = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         check("drain", sb.size(), 0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_req(input string tag, input int budget);
      for (int i = 0; i < budget && w_mem_req !== 1'b1; i++) @(negedge clk);
      check(tag, w_mem_req, 1'b1);
   endtask

   // Monitor: counts REQ cycles, checks latched request fields, and scores each DONE cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            req_cnt = 0;
            low_cnt = 0;
            was_req = 1'b0;
         end else if (w_mem_req) begin
            if (sb.size() == 0) begin
               check("unexpected_req", w_mem_req, 1'b0);
            end else begin
               if (!was_req && sb[0].gap >= 0) check({sb[0].tag, "_gap"}, low_cnt, sb[0].gap);
               check({sb[0].tag, "_addr"}, w_mem_addr, sb[0].addr);
               check({sb[0].tag, "_we"}, w_mem_we, sb[0].we);
               if (sb[0].we) check({sb[0].tag, "_wdata"}, w_mem_wdata, sb[0].wdata);
            end
            check("stall", w_enable, 1'b0);
            req_cnt++;
            was_req = 1'b1;
         end else begin
            if (was_req) begin
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check({e.tag, "_cycles"}, req_cnt, e.req_cycles);
                  check({e.tag, "_din"}, w_din, e.din);
                  check({e.tag, "_err"}, w_err, e.err);
                  check({e.tag, "_en"}, w_enable, 1'b1);
               end
               low_cnt = 1;
            end else begin
               low_cnt++;
               check("idle_err", w_err, 1'b0);
            end
            req_cnt = 0;
            was_req = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_din[0] = 8'h00;
      exp_din[1] = 8'h00;

      // Reset with ack high: everything zero, then enable comes up with no request.
      ack_tied = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_en0", bus0.cpu_enable, 1'b0);
      check("rst_req0", bus0.mem_req, 1'b0);
      check("rst_outs0", {bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.cpu_data_in, bus0.bus_err}, '0);
      check("rst_en3", bus3.cpu_enable, 1'b0);
      check("rst_outs3", {bus3.mem_req, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata, bus3.cpu_data_in, bus3.bus_err}, '0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_en0", bus0.cpu_enable, 1'b1);
      check("post_rst_req0", bus0.mem_req, 1'b0);
      check("post_rst_en3", bus3.cpu_enable, 1'b1);
      check("post_rst_req3", bus3.mem_req, 1'b0);

      // Zero-wait read with ack already high.
      sel   = 1'b0;
      rdata = 8'hA5;
      start_access("rd0", RD, 16'h1234, 8'h00, 1, 8'hA5, 1'b0);
      wait_drain(50);

      // Wait-state instance: read, then a write that must leave cpu_data_in alone.
      sel   = 1'b1;
      rdata = 8'h77;
      start_access("rd3", RD, 16'h0042, 8'h00, 4, 8'h77, 1'b0);
      wait_drain(50);
      rdata = 8'hC3;
      start_access("wr3", WR, 16'hFFFE, 8'h5A, 4, 8'hC3, 1'b0);
      wait_drain(50);

      // Slow memory, request held through DONE; address change mid-access is ignored.
      sel       = 1'b0;
      ack_tied  = 1'b0;
      ack_after = 6;
      rdata     = 8'h11;
      push_exp("b2b_a", RD, 16'h0100, 8'h00, 6, -1, 8'h11, 1'b0);
      push_exp("b2b_b", RD, 16'h0200, 8'h00, 6, 2, 8'h3C, 1'b0);
      @(negedge clk);
      which = RD;
      addr  = 16'h0100;
      req   = 1'b1;
      wait_req("b2b_first_req", 20);
      addr = 16'h0200;
      for (int i = 0; i < 50 && sb.size() > 1; i++) @(negedge clk);
      check("b2b_first_done", sb.size(), 1);
      rdata = 8'h3C;
      wait_req("b2b_second_req", 20);
      req = 1'b0;
      wait_drain(50);
      ack_after = 0;

      // Timeout on a read with memory never acking.
      sel = 1'b1;
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
      start_access("tmo", RD, 16'h4000, 8'h00, 8, 8'h00, 1'b1);
      wait_drain(50);
`else
      mon_en = 1'b0;
      @(negedge clk);
      which = RD;
      addr  = 16'h4000;
      req   = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (100) @(negedge clk);
      check("hang_req", w_mem_req, 1'b1);
      check("hang_err", w_err, 1'b0);
      check("hang_en", w_enable, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_din[0] = 8'h00;
      exp_din[1] = 8'h00;
      @(negedge clk);
      mon_en = 1'b1;
`endif

      // Reset during the second REQ cycle drops the access silently.
      mon_en = 1'b0;
      @(negedge clk);
      which = RD;
      addr  = 16'h2222;
      req   = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("mid_req_before", w_mem_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_req", w_mem_req, 1'b0);
      check("mid_rst_en", w_enable, 1'b0);
      check("mid_rst_err", w_err, 1'b0);
      check("mid_rst_din", w_din, 8'h00);
      rst = 1'b0;
      exp_din[0] = 8'h00;
      exp_din[1] = 8'h00;
      @(negedge clk);
      check("mid_post_en", w_enable, 1'b1);
      check("mid_post_req", w_mem_req, 1'b0);
      @(negedge clk);
      check("mid_idle_req", w_mem_req, 1'b0);
      mon_en = 1'b1;

      // Access after the mid-flight reset starts cleanly from IDLE.
      ack_tied = 1'b1;
      rdata    = 8'hBB;
      start_access("rd_after_rst", RD, 16'h3333, 8'h00, 4, 8'hBB, 1'b0);
      wait_drain(50);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
